rr_hold_arbiter: RTL and testbench
==================================

Name: rr_hold_arbiter

Overview:
Round-robin arbiter with multi-cycle grant ownership for a shared resource, e.g. a bus or memory port.
- The winning requester keeps its grant until it drops its request, signals completion, or exceeds a hold limit.
- Replaces fixed-priority selection where starvation is unacceptable; sits between NUM_PORTS requesters and the shared resource.
- Grant is registered, one-hot, and handed over back-to-back with no idle bubble.

Parameters:
- NUM_PORTS, 4, number of requesters (>=2).
- MAX_HOLD, 16, maximum consecutive grant cycles per ownership; 0 = unlimited.
- ID_W, $clog2(NUM_PORTS), width of gnt_id_o (derived, not overridden).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  NUM_PORTS  request per port; level, held while wanting or using the resource.
- done_i  in  1  current owner ends its transfer this cycle; ignored when no grant.
- gnt_o  out  NUM_PORTS  registered one-hot grant, or all-zero.
- gnt_id_o  out  ID_W  index of the current owner; 0 when idle.
- busy_o  out  1  high whenever gnt_o is non-zero.
- timeout_o  out  1  high during the last cycle of a grant that is being force-released by MAX_HOLD.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous, active-high.
- Reset values: gnt_o=0, gnt_id_o=0, busy_o=0, timeout_o=0, state=IDLE, ptr=0, hold_cnt=0.
- Reset mid-grant drops gnt_o on the next edge; no completion is implied.
- States: IDLE and OWNED.
- Selection function pick(req, ptr): first set bit of req, scanning ptr, ptr+1, ..., wrapping modulo NUM_PORTS.
- IDLE, any req_i set: at the edge, owner = pick(req_i, ptr), gnt_o = onehot(owner), hold_cnt=0, go OWNED. Latency from request to grant is 1 cycle.
- IDLE, req_i==0: stay IDLE.
- OWNED, release condition R = !req_i[owner] OR done_i OR (MAX_HOLD!=0 AND hold_cnt==MAX_HOLD-1).
- OWNED, R false: keep the grant and increment hold_cnt. hold_cnt saturates; it cannot exceed MAX_HOLD-1.
- OWNED, R true: set ptr = (owner+1) mod NUM_PORTS. Compute nxt = pick(req_i with owner bit cleared if !req_i[owner], new ptr).
  - If a candidate exists, grant nxt on the same edge with hold_cnt=0, so there is no bubble.
  - Otherwise go IDLE with gnt_o=0.
  - The old owner is eligible again only after every other requester in the rotation. If it is the sole requester after done or timeout, it is re-granted continuously and gnt_o does not drop.
- timeout_o = OWNED AND MAX_HOLD!=0 AND hold_cnt==MAX_HOLD-1 AND req_i[owner] AND !done_i. It is combinational from registered state plus inputs. done_i has priority over timeout, so no timeout pulse accompanies a done.
- MAX_HOLD=1: every ownership lasts exactly 1 cycle, and timeout_o is high on every cycle without done_i.
- Invariants:
  - gnt_o is one-hot or zero.
  - gnt_id_o always matches gnt_o.
  - A new grant to port k occurs only if req_i[k] was high at the granting edge.
  - No port waits more than (NUM_PORTS-1)*MAX_HOLD + 1 cycles while continuously requesting (MAX_HOLD!=0).

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic {IDLE, OWNED} arb_state_e;
  - a function onehot(idx) for one-hot encoding.
- Sub-module rr_pick: purely combinational rotating priority encoder.
  - Inputs: req, ptr.
  - Outputs: valid, idx.
  - Implementation: double-width masked scan.
  - Instantiated once for both the IDLE and the release selection.

Test Plan:
Default parameters NUM_PORTS=4, MAX_HOLD=4; checks are sampled after each edge.
1. Reset, then req_i=4'b0101 at cycle 1 -> gnt_o=4'b0001, gnt_id_o=0, busy_o=1 at cycle 2; gnt_o=0 for all cycles before that.
2. req_i=4'b1111 held, done_i=1 every cycle -> gnt_o sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, busy_o never drops, timeout_o=0.
3. req_i=4'b0011 held, done_i=0 -> port0 owns exactly 4 cycles with timeout_o=1 in the 4th, then port1 owns 4 cycles, then port0 again.
4. Port2 owns, req_i drops to 4'b0000 -> next cycle gnt_o=0, busy_o=0, state IDLE; then req_i=4'b1111 -> port3 granted (ptr=3).
5. rst_i=1 for one cycle while gnt_o=4'b0100 -> next cycle all outputs 0; then req_i=4'b0110 -> port1 granted (ptr reset to 0).
6. Only req_i[1] held, no done -> gnt_o=4'b0010 continuously, timeout_o pulses every 4th cycle, and gnt_o never goes to 0.

Source files
------------

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg: shared types and helpers for the round-robin hold arbiter.
//   arb_state_e : arbiter FSM states (IDLE, OWNED)
//   onehot()    : index to one-hot vector, up to ONEHOT_MAX_W requesters
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic {IDLE, OWNED} arb_state_e;

  // Widest one-hot vector the helper can produce; callers cast down to their width.
  localparam int ONEHOT_MAX_W = 32;

  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick: combinational rotating priority encoder.
// Returns the first set bit of req_i, scanning ptr_i, ptr_i+1, ... and wrapping.
//   req_i   in  N     request vector
//   ptr_i   in  ID_W  scan start position
//   valid_o out 1     any request set
//   idx_o   out ID_W  selected index (0 when none)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic            valid_o,
  output logic [ID_W-1:0] idx_o
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  // The request vector is laid out twice; masking everything below ptr_i
  // leaves the wrapped-around copy in the upper half, so the lowest
  // surviving bit is the first requester at or after ptr_i in rotation.
  always_comb begin
    // NOTE: every variable gets a default at the top of an always_comb so
    // no path can leave it unassigned and infer a latch.
    dbl    = {req_i, req_i};
    masked = '0;
    idx_o  = '0;
    for (int i = 0; i < 2 * N; i++) begin
      masked[i] = dbl[i] && (i >= int'(ptr_i));
    end
    // Scan downward so the lowest set bit is the last one written.
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (masked[i]) idx_o = ID_W'(i % N);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/rr_hold_arbiter.sv
// -----------------------------------------------------------------------------
// rr_hold_arbiter: round-robin arbiter with multi-cycle grant ownership.
// The owner keeps its grant until it drops its request, pulses done_i, or
// reaches MAX_HOLD consecutive cycles (0 = unlimited). Hand-over is
// back-to-back with no idle cycle. NUM_PORTS is limited to 2..32.
//   clk_i     in  1          clock, rising edge
//   rst_i     in  1          synchronous active-high reset
//   req_i     in  NUM_PORTS  level request per port
//   done_i    in  1          owner finishes this cycle
//   gnt_o     out NUM_PORTS  registered one-hot grant or zero
//   gnt_id_o  out ID_W       owner index, 0 when idle
//   busy_o    out 1          a grant is active
//   timeout_o out 1          current grant is being force-released by MAX_HOLD
// -----------------------------------------------------------------------------
module rr_hold_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int MAX_HOLD  = 16,
  localparam int ID_W      = $clog2(NUM_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 done_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [ID_W-1:0]      gnt_id_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  // Counter only needs to reach MAX_HOLD-1; with MAX_HOLD=0 it is unused
  // beyond saturating.
  localparam int              HOLD_W     = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LIMIT =
    HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;

  logic [ID_W-1:0]      next_ptr;
  logic [ID_W-1:0]      pick_ptr;
  logic [ID_W-1:0]      pick_idx;
  logic                 pick_valid;
  logic                 owner_req;
  logic                 at_limit;
  logic                 release_c;

  assign owner_req = req_i[owner_q];
  assign at_limit  = (MAX_HOLD != 0) && (hold_q == HOLD_LIMIT);
  assign release_c = !owner_req || done_i || at_limit;
  assign next_ptr  = (owner_q == ID_W'(NUM_PORTS - 1)) ? '0 : owner_q + ID_W'(1);

  // The single picker serves both the idle grant (scan from ptr_q) and the
  // release hand-over (scan from the port after the owner). A dropped owner
  // request is already zero in req_i, so no extra masking is needed.
  assign pick_ptr = (state_q == OWNED) ? next_ptr : ptr_q;

  rr_pick #(.N(NUM_PORTS)) u_pick (
    .req_i   (req_i),
    .ptr_i   (pick_ptr),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWNED;
          owner_d = pick_idx;
          gnt_d   = NUM_PORTS'(onehot(int'(pick_idx)));
          hold_d  = '0;
        end
      end
      OWNED: begin
        if (!release_c) begin
          // Saturate for the unlimited case; a finite limit releases first.
          if (hold_q != '1) hold_d = hold_q + HOLD_W'(1);
        end else begin
          ptr_d  = next_ptr;
          hold_d = '0;
          if (pick_valid) begin
            owner_d = pick_idx;
            gnt_d   = NUM_PORTS'(onehot(int'(pick_idx)));
          end else begin
            state_d = IDLE;
            owner_d = '0;
            gnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_id_o  = owner_q;
  assign busy_o    = (state_q == OWNED);
  // done_i wins over the limit, so a completing owner never shows a timeout.
  assign timeout_o = (state_q == OWNED) && at_limit && owner_req && !done_i;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_hold_arbiter: directed scenarios plus randomized traffic against a
// behavioural round-robin model (NUM_PORTS=4, MAX_HOLD=4).
// -----------------------------------------------------------------------------
module tb_rr_hold_arbiter;

  localparam int N     = 4;
  localparam int MH    = 4;
  localparam int BOUND = (N - 1) * MH + 1;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [N-1:0] req_i = '0;
  logic         done_i = 1'b0;
  logic [N-1:0] gnt_o;
  logic [1:0]   gnt_id_o;
  logic         busy_o;
  logic         timeout_o;

  rr_hold_arbiter #(.NUM_PORTS(N), .MAX_HOLD(MH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .done_i    (done_i),
    .gnt_o     (gnt_o),
    .gnt_id_o  (gnt_id_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: owner index (-1 = nobody), rotation pointer, cycles held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  int wait_cnt [N];
  int max_wait = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int start);
    for (int j = 0; j < N; j++) begin
      int p = (start + j) % N;
      if (req[p]) return p;
    end
    return -1;
  endfunction

  function automatic void model_edge(input logic [N-1:0] req, input logic done, input logic rst);
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      m_owner = pick(req, m_ptr);
      m_hold  = 0;
    end else if (req[m_owner] && !done && m_hold < MH - 1) begin
      m_hold++;
    end else begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = pick(req, m_ptr);
      m_hold  = 0;
    end
  endfunction

  // Apply inputs, compare outputs at the falling edge, then advance the model
  // on the rising edge. Returns 1 ns after that edge.
  task automatic step(input logic [N-1:0] req, input logic done, input logic rst);
    logic [31:0] exp_gnt;
    logic        exp_to;
    req_i  = req;
    done_i = done;
    rst_i  = rst;
    @(negedge clk_i);
    exp_gnt = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    exp_to  = (m_owner >= 0) && (m_hold == MH - 1) && req[m_owner] && !done;
    check("gnt",     32'(gnt_o),     exp_gnt);
    check("gnt_id",  32'(gnt_id_o),  (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check("busy",    32'(busy_o),    32'(m_owner >= 0));
    check("timeout", 32'(timeout_o), 32'(exp_to));
    for (int p = 0; p < N; p++) begin
      if (rst || !req[p] || gnt_o[p]) wait_cnt[p] = 0;
      else                            wait_cnt[p]++;
      if (wait_cnt[p] > max_wait) max_wait = wait_cnt[p];
    end
    @(posedge clk_i);
    model_edge(req, done, rst);
    #1;
  endtask

  task automatic do_reset();
    step('0, 1'b0, 1'b1);
  endtask

  logic [N-1:0] seq2 [5];
  logic [N-1:0] rreq;

  initial begin
    for (int p = 0; p < N; p++) wait_cnt[p] = 0;
    @(posedge clk_i);
    #1;

    // 1: first grant one cycle after the request, lowest index from ptr=0.
    do_reset();
    step(4'b0101, 1'b0, 1'b0);
    check("t1_gnt",  32'(gnt_o),    32'h1);
    check("t1_id",   32'(gnt_id_o), 32'h0);
    check("t1_busy", 32'(busy_o),   32'h1);

    // 2: all requesting with done every cycle rotates through every port.
    do_reset();
    seq2[0] = 4'b0001; seq2[1] = 4'b0010; seq2[2] = 4'b0100;
    seq2[3] = 4'b1000; seq2[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1, 1'b0);
      check("t2_gnt",  32'(gnt_o),  32'(seq2[i]));
      check("t2_busy", 32'(busy_o), 32'h1);
    end

    // 3: two ports without done alternate every MAX_HOLD cycles.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      step(4'b0011, 1'b0, 1'b0);
      check("t3_gnt", 32'(gnt_o), (i <= 4) ? 32'h1 : (i <= 8) ? 32'h2 : 32'h1);
    end

    // 4: owner 2 drops, arbiter idles, resumes from ptr=3.
    do_reset();
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    check("t4_own", 32'(gnt_o), 32'h4);
    step(4'b0000, 1'b0, 1'b0);
    check("t4_idle_gnt",  32'(gnt_o),  32'h0);
    check("t4_idle_busy", 32'(busy_o), 32'h0);
    step(4'b1111, 1'b0, 1'b0);
    check("t4_next", 32'(gnt_o), 32'h8);

    // 5: reset during a grant clears outputs and the rotation pointer.
    do_reset();
    step(4'b0100, 1'b0, 1'b0);
    check("t5_own", 32'(gnt_o), 32'h4);
    step(4'b0100, 1'b0, 1'b1);
    check("t5_rst_gnt",  32'(gnt_o),  32'h0);
    check("t5_rst_busy", 32'(busy_o), 32'h0);
    step(4'b0110, 1'b0, 1'b0);
    check("t5_ptr0", 32'(gnt_o), 32'h2);

    // 6: a sole requester is re-granted through timeouts without a gap.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(4'b0010, 1'b0, 1'b0);
      check("t6_gnt", 32'(gnt_o), 32'h2);
    end

    // Random traffic: sticky requests, occasional done and reset.
    do_reset();
    rreq = '0;
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(0, 4) == 0) rreq[p] = ~rreq[p];
      end
      step(rreq, ($urandom_range(0, 3) == 0), ($urandom_range(0, 79) == 0));
    end

    check("max_wait_within_bound", 32'(max_wait <= BOUND), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
